// File: rtl/rv_mem_ifc_pkg.sv
// Shared types and constants for the multicycle core's memory bus interface.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT   = 16;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;
    localparam logic [1:0]  ALIGN_OK          = 2'b00;

    // Only word accesses exist on this bus, so the two low address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == ALIGN_OK;
    endfunction

endpackage

// File: rtl/rv_mem_ifc_if.sv
// Core-side and bus-side signals of the memory interface; the block itself uses the slave view.
interface rv_mem_ifc_if;

    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_done;
    logic        core_err;
    logic        core_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, bus_rdata, bus_ack,
        output core_rdata, core_done, core_err, core_stall,
               bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, bus_rdata, bus_ack,
        input  core_rdata, core_done, core_err, core_stall,
               bus_req, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/rv_mem_ifc_timeout_cnt.sv
// Saturating 8-bit wait-state counter; tc_o flags the last bus cycle before an abort.
module rv_timeout_cnt
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VALUE = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VALUE);

endmodule

// File: rtl/rv_mem_ifc.sv
// Turns the core's single-cycle memory access into a bus request/ack transaction
// with wait states, reporting misaligned or timed-out accesses as errors.
module rv_mem_ifc
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,
    rv_mem_ifc_if.slave mem
);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;

    rv_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .tc_o (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // An ack sampled together with the terminal count still completes normally.
    always_comb begin
        state_d   = state_q;
        bus_req_d = bus_req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem.core_req) begin
                    if (is_aligned(mem.core_addr[1:0])) begin
                        state_d   = BUSY;
                        bus_req_d = 1'b1;
                        we_d      = mem.core_we;
                        addr_d    = mem.core_addr;
                        wdata_d   = mem.core_wdata;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (mem.bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem.bus_rdata;
                    end
                end else if (cnt_tc) begin
                    state_d   = ERR;
                    bus_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = ERR_RDATA;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem.core_rdata = rdata_q;
    assign mem.core_done  = (state_q == DONE) || (state_q == ERR);
    assign mem.core_err   = (state_q == ERR);
    assign mem.core_stall = ((state_q == IDLE) && mem.core_req) || (state_q == BUSY);
    assign mem.bus_req    = bus_req_q;
    assign mem.bus_we     = we_q;
    assign mem.bus_addr   = addr_q;
    assign mem.bus_wdata  = wdata_q;

endmodule

// File: doc/rv_mem_ifc.md
# rv_mem_ifc

Memory bus interface for the multicycle RISC-V core. It sits between the core and a variable-latency memory bus. The control plane's single-cycle access (instruction fetch, load data capture, store write) becomes a request/acknowledge transaction with wait states. The block returns a stall to the core, captures read data, and reports misaligned or timed-out accesses as errors.

## Interface
Parameters:
- TIMEOUT, default 16: bus cycles allowed without bus_ack before the access is aborted; legal range 2..255.
- ERR_RDATA, default 32'hDEAD_BEEF: value loaded into core_rdata on an aborted read.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- core_req  in  1  access request; level, held by the core until core_done.
- core_we  in  1  1 = store, 0 = load or fetch.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data.
- core_rdata  out  32  registered read data; held until the next read completes.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  one-cycle pulse, coincident with core_done, on an abort.
- core_stall  out  1  core must not advance state while high.
- bus_req  out  1  bus request; registered.
- bus_we  out  1  registered copy of core_we.
- bus_addr  out  32  registered copy of core_addr.
- bus_wdata  out  32  registered copy of core_wdata.
- bus_rdata  in  32  read data; valid when bus_ack = 1.
- bus_ack  in  1  transfer complete; one cycle.

## Operation
States:
- IDLE
  - core_req = 1 with core_addr[1:0] = 0: latch we, addr and wdata; clear the timeout counter; go to BUSY.
  - core_req = 1 with core_addr[1:0] != 0: go to ERR; no bus access is made.
  - Otherwise stay in IDLE.
- BUSY
  - bus_req = 1.
  - bus_ack = 1 and latched we = 0: load core_rdata from bus_rdata; go to DONE.
  - bus_ack = 1 and latched we = 1: go to DONE; core_rdata is unchanged.
  - No ack and counter = TIMEOUT-1: go to ERR. If the access is a read, load ERR_RDATA into core_rdata.
  - Otherwise increment the counter.
- DONE: core_done = 1; go to IDLE.
- ERR: core_done = 1 and core_err = 1; go to IDLE.

Outputs and rules:
- core_stall = (state = IDLE and core_req = 1) or state = BUSY. It is combinational and low in DONE and ERR, so the core advances in the completion cycle.
- The core deasserts core_req in the cycle after core_done. A request still high in IDLE is treated as a new access.
- bus_we, bus_addr and bus_wdata stay stable for the whole time bus_req is high.
- bus_ack outside BUSY is ignored.
- bus_ack in the same cycle that the counter reaches TIMEOUT-1: the ack wins and the access completes normally.
- The counter is 8 bits wide and saturates; it never wraps.

## Timing
- Reset (rst = 0 at an edge): state = IDLE, counter = 0, core_rdata = 0, bus_* = 0, core_done = 0, core_err = 0. core_stall then follows core_req.
- Reset mid-transaction: bus_req drops at that edge and the access is discarded without core_done.
- Accept edge = t0:
  - bus_req is high from t0 until the edge that samples bus_ack.
  - If bus_ack is first sampled high at edge tk (k >= 1), core_done is high in cycle tk to tk+1.
  - Minimum request-to-done latency is 2 cycles, with ack in the first bus cycle.
- Timeout: with no ack, ERR is entered at edge t0+TIMEOUT and core_done/core_err pulse in the following cycle. bus_req is high for exactly TIMEOUT cycles.
- Misaligned access: ERR is entered at t0 and core_done/core_err pulse in the following cycle. bus_req never rises.
- core_rdata is updated at the same edge that enters DONE or ERR.

## Structure
- Package rv_mem_pkg holds:
  - the state enum (IDLE, BUSY, DONE, ERR);
  - the default TIMEOUT and ERR_RDATA constants;
  - the alignment-check constant (2'b00).
- Sub-module rv_timeout_cnt: saturating 8-bit counter with clear, enable and terminal-count output (count = TIMEOUT-1). It is instantiated once.
- The remainder is a single FSM with registered bus outputs. Target size is about 150–250 lines.

## Test plan
- Read, ack in first bus cycle: addr 0x100, bus_rdata 0x12345678. Required: bus_req high 1 cycle, core_done 2 cycles after accept, core_rdata = 0x12345678, core_err = 0.
- Store with 3 wait states: addr 0x200, wdata 0xA5A5A5A5. Required: bus_we = 1, bus_wdata stable for all 4 cycles of bus_req, core_rdata unchanged, one core_done.
- Misaligned load: addr 0x103. Required: bus_req never rises; core_done and core_err pulse together 1 cycle after accept.
- No ack, TIMEOUT = 16, read. Required: bus_req high exactly 16 cycles, then core_err and core_done pulse, core_rdata = 0xDEADBEEF.
- Ack on the terminal-count cycle (cycle 16 of bus_req). Required: normal completion, core_err = 0, core_rdata = bus_rdata.
- rst = 0 during BUSY. Required: at the next edge bus_req = 0, all outputs are at reset values, no core_done; a following access behaves normally.
